// File: rtl/pulse_stretch_if.sv
// Event-in / level-out signal bundle for pulse_stretch_driver.
// Handshake: pulse_in is a plain strobe with no ready; each cycle it is sampled high counts as one event.
interface pulse_stretch_if #(
    parameter int PEND_BITS = 4
);
    logic                 pulse_in;
    logic                 out_level;
    logic                 busy;
    logic [PEND_BITS-1:0] pending;
    logic                 overflow;

    modport master (
        output pulse_in,
        input  out_level,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output out_level,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretch_driver.sv
// Turns single-cycle event pulses into fixed-length on-periods separated by a mandatory off-gap,
// replaying events that arrive while busy from a saturating pending counter.
module pulse_stretch_driver #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int ON_MS     = 50,
    parameter int OFF_MS    = 50,
    parameter int PEND_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    pulse_stretch_if.slave   bus,
    output logic [1:0]       dbg_state_o
);
    localparam int ON_CYCLES  = CLK_FREQ / 1000 * ON_MS;
    localparam int OFF_CYCLES = CLK_FREQ / 1000 * OFF_MS;
    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0]        ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]        OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_BITS-1:0] PEND_MAX = {PEND_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [PEND_BITS-1:0] pend_q, pend_d;
    logic                 ovf_q, ovf_d;
    logic                 out_q, out_d;
    logic                 queue_ev;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        queue_ev = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.pulse_in) begin
                    state_d = ON;
                    timer_d = ON_LOAD;
                end
            end
            ON: begin
                queue_ev = bus.pulse_in;
                if (timer_q == '0) begin
                    state_d = GAP;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (timer_q != '0) begin
                    timer_d  = timer_q - TW'(1);
                    queue_ev = bus.pulse_in;
                end else if (pend_q != '0) begin
                    // A pulse on this cycle takes the slot freed by the replayed event.
                    state_d = ON;
                    timer_d = ON_LOAD;
                    if (!bus.pulse_in) pend_d = pend_q - PEND_BITS'(1);
                end else if (bus.pulse_in) begin
                    state_d = ON;
                    timer_d = ON_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        if (queue_ev) begin
            if (pend_q == PEND_MAX) ovf_d = 1'b1;
            else                    pend_d = pend_q + PEND_BITS'(1);
        end

        out_d = (state_d == ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end

    assign bus.out_level = out_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.pending   = pend_q;
    assign bus.overflow  = ovf_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Bench for pulse_stretch_driver: start-time based reference model, per-cycle compare, directed literal checks.
module tb_pulse_stretch_driver;
  localparam int ON_C   = 3;
  localparam int OFF_C  = 2;
  localparam int PB     = 2;
  localparam int P_MAX  = 3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  pulse_stretch_if #(.PEND_BITS(PB)) tif ();

  pulse_stretch_driver #(
    .CLK_FREQ(1000), .ON_MS(3), .OFF_MS(2), .PEND_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .bus(tif.slave), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // reference model: an on-period is an absolute start cycle s; activity spans s .. s+ON+OFF-1
  longint cyc = 0;
  longint m_start = 0;
  bit     m_active = 1'b0;
  int     m_pend = 0;
  bit     m_ovf = 1'b0;
  bit     m_out = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_pend   = 0;
      m_ovf    = 1'b0;
    end else if (!m_active) begin
      if (tif.pulse_in) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
      end
    end else if (cyc == m_start + ON_C + OFF_C - 1) begin
      if (m_pend > 0) begin
        m_start = cyc + 1;
        if (!tif.pulse_in) m_pend--;
      end else if (tif.pulse_in) begin
        m_start = cyc + 1;
      end else begin
        m_active = 1'b0;
      end
    end else if (tif.pulse_in) begin
      if (m_pend == P_MAX) m_ovf = 1'b1;
      else                 m_pend++;
    end
    cyc++;
    m_out = m_active && ((cyc - m_start) < ON_C);
  end

  // compare process
  always @(negedge clk) begin
    if (check_en) begin
      check("out_level", int'(tif.out_level), int'(m_out));
      check("busy",      int'(tif.busy),      int'(m_active));
      check("pending",   int'(tif.pending),   m_pend);
      check("overflow",  int'(tif.overflow),  int'(m_ovf));
    end
  end

  // driver tasks
  task automatic step(input logic p, input logic r);
    tif.pulse_in = p;
    rst = r;
    @(negedge clk);
  endtask

  task automatic idle_for(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
  endtask

  logic [6:0] out_seq, busy_seq;

  initial begin
    tif.pulse_in = 1'b0;
    rst = 1'b1;
    do_reset();
    check_en = 1'b1;
    check("reset_out",  int'(tif.out_level), 0);
    check("reset_busy", int'(tif.busy), 0);
    check("reset_pend", int'(tif.pending), 0);

    // single pulse: cycles 1..7
    step(1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      out_seq[i]  = tif.out_level;
      busy_seq[i] = tif.busy;
      step(1'b0, 1'b0);
    end
    check("single_out_seq",  int'(out_seq),  int'(7'b1110000));
    check("single_busy_seq", int'(busy_seq), int'(7'b1111100));
    idle_for(3);

    // back-to-back: pending=1 at cycle 2
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("b2b_pending", int'(tif.pending), 1);
    idle_for(12);

    // pulse on last gap cycle goes straight to ON
    step(1'b1, 1'b0);
    idle_for(4);
    step(1'b1, 1'b0);
    check("lastgap_out",  int'(tif.out_level), 1);
    check("lastgap_pend", int'(tif.pending), 0);
    idle_for(8);

    // overflow: held high cycles 0..4
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("ovf_pend3",  int'(tif.pending), 3);
    check("ovf_before", int'(tif.overflow), 0);
    step(1'b1, 1'b0);
    check("ovf_set",    int'(tif.overflow), 1);
    idle_for(22);
    check("ovf_idle_busy",   int'(tif.busy), 0);
    check("ovf_idle_sticky", int'(tif.overflow), 1);

    // reset mid-operation with pulse_in high
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("rst_mid_out",  int'(tif.out_level), 0);
    check("rst_mid_busy", int'(tif.busy), 0);
    check("rst_mid_ovf",  int'(tif.overflow), 0);
    idle_for(6);

    // spaced pulses every 5 cycles
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      idle_for(4);
    end
    idle_for(6);

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      int dens;
      dens = (i / 500) % 4;
      step(($urandom_range(0, 9) < dens * 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    idle_for(30);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
